// File: rtl/pipe_pkg.sv
// Shared types and default widths for the valid/ready inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_t;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 24;
  localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer, flush-to-bubble and a
// saturating stall counter. in_ready is registered, so upstream never sees out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t state_q, state_d;

  logic [DATA_W-1:0] main_data_p0, skid_data_p0;
  logic [CTRL_W-1:0] main_ctrl_p0, skid_ctrl_p0;

  logic accept, deliver;
  logic load_main_in, load_main_skid, load_skid;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = FULL;
            load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (accept && deliver) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (deliver) begin
            state_d        = FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != SKID);
    end
  end

  // ---- stage boundary: main (head) and skid entries ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_p0 <= '0;
      main_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else begin
      if (load_main_in) begin
        main_data_p0 <= in_data;
      end else if (load_main_skid) begin
        main_data_p0 <= skid_data_p0;
      end
      if (load_skid) begin
        skid_data_p0 <= in_data;
      end
      // Flush kills the control payload so a bubble can never write state downstream.
      if (flush) begin
        main_ctrl_p0 <= '0;
        skid_ctrl_p0 <= '0;
      end else begin
        if (load_main_in) begin
          main_ctrl_p0 <= in_ctrl;
        end else if (load_main_skid) begin
          main_ctrl_p0 <= skid_ctrl_p0;
        end
        if (load_skid) begin
          skid_ctrl_p0 <= in_ctrl;
        end
      end
    end
  end

  assign out_data = main_data_p0;
  assign out_ctrl = out_valid ? main_ctrl_p0 : '0;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush, saturation, async reset.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, DW'(i + 3), CW'(8'hF0 + i));
      out_ready = i[0];
      flush     = i[1];
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_ctrl",  32'(out_ctrl),  32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    end
    check("rst_out_data", 32'(out_data), 32'd0);
    flush = 1'b0;
    offer(1'b0, '0, '0);
    rst_n = 1'b1;

    // Streaming 0x1..0x8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, DW'(i), CW'(8'h10 + i));
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data",  32'(out_data),  32'(i));
      check("stream_ctrl",  32'(out_ctrl),  32'(8'h10 + i));
      check("stream_ready", 32'(in_ready),  32'd1);
    end
    offer(1'b0, '0, '0);
    tick();
    check("stream_drain_valid", 32'(out_valid), 32'd0);
    check("stream_drain_ctrl",  32'(out_ctrl),  32'd0);
    check("stream_stall_cnt",   32'(stall_cnt), 32'd0);

    // Back-pressure: A held, B in skid, C refused
    out_ready = 1'b0;
    offer(1'b1, 16'h000A, 8'h2A);
    tick();
    check("bp_a_data",  32'(out_data), 32'h000A);
    check("bp_a_ready", 32'(in_ready), 32'd1);
    offer(1'b1, 16'h000B, 8'h2B);
    tick();
    check("bp_skid_ready", 32'(in_ready), 32'd0);
    check("bp_skid_data",  32'(out_data), 32'h000A);
    offer(1'b1, 16'h000C, 8'h2C);
    tick();
    tick();
    tick();
    check("bp_hold_data",  32'(out_data),  32'h000A);
    check("bp_hold_ctrl",  32'(out_ctrl),  32'h2A);
    check("bp_hold_ready", 32'(in_ready),  32'd0);
    check("bp_stall_cnt",  32'(stall_cnt), 32'd4);
    out_ready = 1'b1;
    tick();
    check("bp_rel_b_data",  32'(out_data), 32'h000B);
    check("bp_rel_b_ctrl",  32'(out_ctrl), 32'h2B);
    check("bp_rel_ready",   32'(in_ready), 32'd1);
    tick();
    check("bp_rel_c_data",  32'(out_data), 32'h000C);
    check("bp_rel_c_valid", 32'(out_valid), 32'd1);
    offer(1'b0, '0, '0);
    tick();
    check("bp_empty_valid", 32'(out_valid), 32'd0);
    check("bp_final_cnt",   32'(stall_cnt), 32'd4);

    // Flush while in SKID with a beat offered
    out_ready = 1'b0;
    offer(1'b1, 16'h000D, 8'h3D);
    tick();
    offer(1'b1, 16'h000E, 8'h3E);
    tick();
    check("fl_pre_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    offer(1'b1, 16'h000F, 8'h3F);
    tick();
    flush = 1'b0;
    check("fl_valid",     32'(out_valid), 32'd0);
    check("fl_ctrl",      32'(out_ctrl),  32'd0);
    check("fl_ready",     32'(in_ready),  32'd1);
    check("fl_stall_cnt", 32'(stall_cnt), 32'd6);
    out_ready = 1'b1;
    offer(1'b1, 16'h0011, 8'h51);
    tick();
    check("fl_next_data", 32'(out_data), 32'h0011);
    check("fl_next_ctrl", 32'(out_ctrl), 32'h51);
    offer(1'b0, '0, '0);
    tick();
    check("fl_next_drain", 32'(out_valid), 32'd0);

    // Flush + deliver + accept together in FULL
    offer(1'b1, 16'h0021, 8'h61);
    tick();
    check("fda_full_data", 32'(out_data), 32'h0021);
    flush = 1'b1;
    offer(1'b1, 16'h0022, 8'h62);
    tick();
    flush = 1'b0;
    check("fda_valid", 32'(out_valid), 32'd0);
    offer(1'b0, '0, '0);
    tick();
    check("fda_dropped", 32'(out_valid), 32'd0);
    check("fda_cnt",     32'(stall_cnt), 32'd6);

    // Saturation of the 4-bit stall counter
    out_ready = 1'b0;
    offer(1'b1, 16'h0030, 8'h70);
    tick();
    offer(1'b0, '0, '0);
    check("sat_start", 32'(stall_cnt), 32'd6);
    for (int i = 0; i < 8; i++) tick();
    check("sat_14", 32'(stall_cnt), 32'd14);
    tick();
    check("sat_15", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 11; i++) tick();
    check("sat_hold", 32'(stall_cnt), 32'd15);

    // Asynchronous reset mid-stall in SKID
    offer(1'b1, 16'h0031, 8'h71);
    tick();
    check("ar_pre_ready", 32'(in_ready), 32'd0);
    offer(1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready),  32'd1);
    check("ar_data",  32'(out_data),  32'd0);
    check("ar_ctrl",  32'(out_ctrl),  32'd0);
    check("ar_cnt",   32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar_no_ghost", 32'(out_valid), 32'd0);
    offer(1'b1, 16'h0040, 8'h44);
    tick();
    check("ar_first_data", 32'(out_data), 32'h0040);
    check("ar_first_ctrl", 32'(out_ctrl), 32'h44);
    offer(1'b0, '0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
